// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns load/store controller strobes into one req/ack bus transfer and stalls the pipeline until it completes.
// Optional bus watchdog: define DMEM_BUS_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES wait cycles.
module dmem_bus_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic                  write,
    input  logic                  exception,
    input  logic [3:0]            maskByte,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           writeData,
    output logic [31:0]           dataMemOut,
    output logic                  stall,
    output logic                  done,
    output logic                  fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ack,
    input  logic                  bus_err,
    output logic [1:0]            dbg_state
);

    // Bus handshake: bus_req rises the cycle after accept and stays high, with
    // bus_we/addr/be/wdata held stable, until a cycle in which bus_ack or
    // bus_err is sampled high (bus_err wins); it then drops for at least one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t state;
    state_t state_nx;
    logic   accept;
    logic   capture;
    logic   fault_nx;
    logic   req_timeout;

    assign dbg_state = state;

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    // Counts REQ cycles that ended without a response; zero whenever outside REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state != REQ) begin
            wait_cnt <= '0;
        end else if (!bus_ack && !bus_err) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign req_timeout = (state == REQ) && !bus_ack && !bus_err &&
                         (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign req_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        fault_nx = 1'b0;
        case (state)
            IDLE: begin
                if ((read || write) && !exception) begin
                    stall = 1'b1;
                    if (read && write) begin
                        state_nx = DONE;
                        fault_nx = 1'b1;
                    end else begin
                        accept   = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_err) begin
                    state_nx = DONE;
                    fault_nx = 1'b1;
                end else if (bus_ack) begin
                    state_nx = DONE;
                    capture  = !bus_we;
                end else if (req_timeout) begin
                    state_nx = DONE;
                    fault_nx = 1'b1;
                end
            end
            DONE: begin
                // Strobes still belong to the completing instruction here.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            dataMemOut <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            bus_req <= (state_nx == REQ);
            // DONE always returns to IDLE, so entering it is a single-cycle pulse.
            done    <= (state_nx == DONE);
            fault   <= fault_nx;
            if (accept) begin
                bus_addr  <= address & WORD_MASK;
                bus_be    <= maskByte;
                bus_wdata <= writeData;
                bus_we    <= write;
            end
            if (capture) begin
                dataMemOut <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed bench with a transaction-level reference model and per-cycle compare.
module tb_dmem_bus_bridge;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic        exception = 1'b0;
    logic [3:0]  maskByte = '0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] dataMemOut;
    logic        stall;
    logic        done;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int n_stall, n_req, n_done, n_fault;

    dmem_bus_bridge #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .read(read), .write(write), .exception(exception),
        .maskByte(maskByte), .address(address), .writeData(writeData),
        .dataMemOut(dataMemOut), .stall(stall), .done(done), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: one outstanding transfer, a completion pulse, the last read word
    logic        m_busy, m_done, m_fault, m_we;
    logic [31:0] m_dout, m_addr, m_wdata;
    logic [3:0]  m_be;
    int          m_wait;

    task automatic m_finish(input logic f);
        m_busy  = 1'b0;
        m_done  = 1'b1;
        m_fault = f;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_fault = 0; m_we = 0;
            m_dout = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_wait = 0;
        end else if (m_done) begin
            m_done  = 1'b0;
            m_fault = 1'b0;
        end else if (m_busy) begin
            if (bus_err) begin
                m_finish(1'b1);
            end else if (bus_ack) begin
                if (!m_we) m_dout = bus_rdata;
                m_finish(1'b0);
            end else begin
                m_wait++;
`ifdef DMEM_BUS_TIMEOUT_EN
                if (m_wait == TO) m_finish(1'b1);
`endif
            end
        end else if ((read || write) && !exception) begin
            if (read && write) begin
                m_done  = 1'b1;
                m_fault = 1'b1;
            end else begin
                m_busy  = 1'b1;
                m_wait  = 0;
                m_addr  = {address[31:2], 2'b00};
                m_be    = maskByte;
                m_wdata = writeData;
                m_we    = write;
            end
        end
    end

    // per-cycle compare and event counters, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("stall", stall, m_busy || (!m_done && (read || write) && !exception));
            chk("bus_req", bus_req, m_busy);
            chk("done", done, m_done);
            chk("fault", fault, m_fault);
            chk("dataMemOut", dataMemOut, m_dout);
            if (m_busy) begin
                chk("bus_we", bus_we, m_we);
                chk("bus_addr", bus_addr, m_addr);
                chk("bus_be", bus_be, m_be);
                chk("bus_wdata", bus_wdata, m_wdata);
            end
            if (stall) n_stall++;
            if (bus_req) n_req++;
            if (done) n_done++;
            if (done && fault) n_fault++;
        end
    end

    // driver: waits < 0 means no bus phase is expected
    task automatic access(input logic rd, input logic wr, input logic exc,
                          input logic [3:0] mask, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits,
                          input logic ack, input logic err, input logic [31:0] rdata);
        n_stall = 0; n_req = 0; n_done = 0; n_fault = 0;
        read = rd; write = wr; exception = exc;
        maskByte = mask; address = addr; writeData = wdata;
        tick();
        read = 1'b0; write = 1'b0; exception = 1'b0;
        if (waits >= 0) begin
            for (int i = 0; i < waits; i++) tick();
            bus_ack = ack; bus_err = err; bus_rdata = rdata;
            tick();
            bus_ack = 1'b0; bus_err = 1'b0;
        end
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // reset state
        #2;
        chk("rst bus_req", bus_req, 0);
        chk("rst stall", stall, 0);
        chk("rst done", done, 0);
        chk("rst fault", fault, 0);
        chk("rst dataMemOut", dataMemOut, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_be", bus_be, 0);
        chk("rst bus_we", bus_we, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // zero-wait load
        access(1, 0, 0, 4'b1111, 32'h1006, 0, 0, 1, 0, 32'hDEADBEEF);
        chk("ld0 dataMemOut", dataMemOut, 32'hDEADBEEF);
        chk("ld0 stall cycles", n_stall, 2);
        chk("ld0 req cycles", n_req, 1);
        chk("ld0 done pulses", n_done, 1);
        chk("ld0 faults", n_fault, 0);
        chk("ld0 bus_addr", bus_addr, 32'h1004);

        // store with 3 wait states
        access(0, 1, 0, 4'b0110, 32'h20, 32'h00ABCD00, 3, 1, 0, 32'h55555555);
        chk("st dataMemOut", dataMemOut, 32'hDEADBEEF);
        chk("st req cycles", n_req, 4);
        chk("st stall cycles", n_stall, 5);
        chk("st done pulses", n_done, 1);
        chk("st bus_be", bus_be, 4'b0110);
        chk("st bus_wdata", bus_wdata, 32'h00ABCD00);

        // error wins over ack
        access(1, 0, 0, 4'b1111, 32'h44, 0, 1, 1, 1, 32'h12345678);
        chk("err dataMemOut", dataMemOut, 32'hDEADBEEF);
        chk("err faults", n_fault, 1);
        chk("err done pulses", n_done, 1);

        // suppressed by exception, with stray ack/err outside REQ
        bus_ack = 1'b1; bus_err = 1'b1;
        access(1, 0, 1, 4'b1111, 32'h48, 0, -1, 0, 0, 0);
        bus_ack = 1'b0; bus_err = 1'b0;
        chk("exc req cycles", n_req, 0);
        chk("exc stall cycles", n_stall, 0);
        chk("exc done pulses", n_done, 0);

        // illegal read+write
        access(1, 1, 0, 4'b1111, 32'h4C, 32'h1, -1, 0, 0, 0);
        chk("ill req cycles", n_req, 0);
        chk("ill done pulses", n_done, 1);
        chk("ill faults", n_fault, 1);
        chk("ill stall cycles", n_stall, 1);

`ifdef DMEM_BUS_TIMEOUT_EN
        // watchdog expiry, then ack on the last allowed cycle
        access(1, 0, 0, 4'b1111, 32'h80, 0, TO - 1, 0, 0, 0);
        chk("to req cycles", n_req, TO);
        chk("to faults", n_fault, 1);
        chk("to dataMemOut", dataMemOut, 32'hDEADBEEF);
        access(1, 0, 0, 4'b1111, 32'h84, 0, TO - 1, 1, 0, 32'h0BADF00D);
        chk("to-ack req cycles", n_req, TO);
        chk("to-ack faults", n_fault, 0);
        chk("to-ack dataMemOut", dataMemOut, 32'h0BADF00D);
`else
        // long wait must not time out
        access(1, 0, 0, 4'b1111, 32'h84, 0, 20, 1, 0, 32'h0BADF00D);
        chk("long req cycles", n_req, 21);
        chk("long faults", n_fault, 0);
        chk("long dataMemOut", dataMemOut, 32'h0BADF00D);
`endif

        // reset in the 2nd REQ cycle
        n_stall = 0; n_req = 0; n_done = 0; n_fault = 0;
        read = 1'b1; maskByte = 4'b1111; address = 32'h3008;
        tick();
        read = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid-rst bus_req", bus_req, 0);
        chk("mid-rst dataMemOut", dataMemOut, 0);
        chk("mid-rst stall", stall, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("mid-rst done pulses", n_done, 0);

        // normal load after reset
        access(1, 0, 0, 4'b1111, 32'h47, 0, 2, 1, 0, 32'hCAFEF00D);
        chk("post dataMemOut", dataMemOut, 32'hCAFEF00D);
        chk("post done pulses", n_done, 1);
        chk("post faults", n_fault, 0);
        chk("post bus_addr", bus_addr, 32'h44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
